// File: rtl/lcd_pkg.sv
// Shared types, opcode masks and DDRAM address helpers for the character-LCD bus responder.
// The display buffer is two 16-character lines mapped at DDRAM bases 0x00 and 0x40.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR_FILL,
    ST_BUSY
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_HOME,
    CMD_ENTRY,
    CMD_DISPLAY,
    CMD_SHIFT,
    CMD_DDRAM
  } cmd_e;

  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LAST_COL   = 7'h0F;

  localparam int         BUF_DEPTH  = 32;
  localparam logic [7:0] BLANK_CHAR = 8'h20;

  // Instructions are identified by their most significant set bit.
  function automatic cmd_e decode_cmd(input logic [7:0] op);
    if ((op & OP_DDRAM) != 8'h00)              return CMD_DDRAM;
    if ((op & (OP_CGRAM | OP_FUNC)) != 8'h00)  return CMD_NONE;
    if ((op & OP_SHIFT) != 8'h00)              return CMD_SHIFT;
    if ((op & OP_DISPLAY) != 8'h00)            return CMD_DISPLAY;
    if ((op & OP_ENTRY) != 8'h00)              return CMD_ENTRY;
    if ((op & OP_HOME) != 8'h00)               return CMD_HOME;
    if ((op & OP_CLEAR) != 8'h00)              return CMD_CLEAR;
    return CMD_NONE;
  endfunction

  function automatic logic addr_valid(input logic [6:0] a);
    return ((a & 7'h70) == LINE1_BASE) || ((a & 7'h70) == LINE2_BASE);
  endfunction

  function automatic logic [4:0] addr_index(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

  // Moves one column, wrapping from the end of a line onto the other line.
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a[3:0] == 4'hF) return a[6] ? LINE1_BASE : LINE2_BASE;
      return a + 7'd1;
    end
    if (a[3:0] == 4'h0) return (a[6] ? LINE1_BASE : LINE2_BASE) | LAST_COL;
    return a - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_sync.sv
// Two-flop synchroniser for the asynchronous LCD bus inputs plus an EN falling-edge detector.
module lcd_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_in,
  input  logic       rs_in,
  input  logic       rw_in,
  input  logic [7:0] data_in,
  output logic       en_s,
  output logic       rs_s,
  output logic       rw_s,
  output logic [7:0] data_s,
  output logic       en_fall
);

  logic [10:0] meta_q, meta_d;
  logic [10:0] sync_q, sync_d;
  logic        en_prev_q, en_prev_d;

  always_comb begin
    meta_d    = {en_in, rs_in, rw_in, data_in};
    sync_d    = meta_q;
    en_prev_d = sync_q[10];
  end

  // NOTE: non-blocking assignments let each stage sample its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= '0;
      sync_q    <= '0;
      en_prev_q <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      en_prev_q <= en_prev_d;
    end
  end

  assign {en_s, rs_s, rw_s, data_s} = sync_q;
  assign en_fall = en_prev_q & ~en_s;

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style bus responder: accepts instruction/data writes, serves status/data reads,
// and keeps a 2x16 display buffer readable by the host through rd_addr/rd_data.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic [7:0] LCD_DATA_in,
  output logic [7:0] LCD_DATA_out,
  output logic       LCD_DATA_oe,
  output logic       busy,
  output logic       disp_on,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       protocol_err
);

  // The fill phase already accounts for BUF_DEPTH cycles of the clear busy time.
  localparam int          CLEAR_TAIL = (CLEAR_CYCLES > BUF_DEPTH) ? (CLEAR_CYCLES - BUF_DEPTH) : 1;
  localparam logic [31:0] BUSY_LOAD  = 32'((BUSY_CYCLES > 1) ? (BUSY_CYCLES - 1) : 0);
  localparam logic [31:0] TAIL_LOAD  = 32'(CLEAR_TAIL - 1);

  logic       en_s, rs_s, rw_s, en_fall;
  logic [7:0] data_s;

  lcd_sync u_sync (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .en_in   (LCD_EN),
    .rs_in   (LCD_RS),
    .rw_in   (LCD_RW),
    .data_in (LCD_DATA_in),
    .en_s    (en_s),
    .rs_s    (rs_s),
    .rw_s    (rw_s),
    .data_s  (data_s),
    .en_fall (en_fall)
  );

  state_e      state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic        id_q, id_d;
  logic        disp_q, disp_d;
  logic        perr_q, perr_d;
  logic        cmd_rs_q, cmd_rs_d;
  logic [7:0]  cmd_data_q, cmd_data_d;
  logic [4:0]  fill_q, fill_d;
  logic [31:0] cnt_q, cnt_d;

  logic [7:0]  buf_q [BUF_DEPTH];
  logic        buf_we;
  logic [4:0]  buf_widx;
  logic [7:0]  buf_wdata;

  assign busy = (state_q == ST_CLEAR_FILL) || (state_q == ST_BUSY);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    id_d       = id_q;
    disp_d     = disp_q;
    perr_d     = 1'b0;
    cmd_rs_d   = cmd_rs_q;
    cmd_data_d = cmd_data_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    buf_we     = 1'b0;
    buf_widx   = addr_index(addr_q);
    buf_wdata  = cmd_data_q;

    // Data reads only move the cursor, and never while the FSM itself owns addr.
    if (en_fall && rw_s && rs_s && (state_q == ST_IDLE || state_q == ST_BUSY)) begin
      addr_d = addr_step(addr_q, id_q);
    end
    if (en_fall && !rw_s && state_q != ST_IDLE) begin
      perr_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (en_fall && !rw_s) begin
          cmd_rs_d   = rs_s;
          cmd_data_d = data_s;
          state_d    = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_BUSY;
        cnt_d   = BUSY_LOAD;
        if (cmd_rs_q) begin
          buf_we = 1'b1;
          addr_d = addr_step(addr_q, id_q);
        end else begin
          case (decode_cmd(cmd_data_q))
            CMD_CLEAR: begin
              state_d = ST_CLEAR_FILL;
              fill_d  = 5'd0;
              addr_d  = LINE1_BASE;
              id_d    = 1'b1;
            end
            CMD_HOME:    addr_d = LINE1_BASE;
            CMD_ENTRY:   id_d   = cmd_data_q[1];
            CMD_DISPLAY: disp_d = cmd_data_q[2];
            CMD_SHIFT: begin
              if (!cmd_data_q[3]) addr_d = addr_step(addr_q, cmd_data_q[2]);
            end
            CMD_DDRAM: begin
              if (addr_valid(cmd_data_q[6:0])) addr_d = cmd_data_q[6:0];
              else                             perr_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_CLEAR_FILL: begin
        buf_we    = 1'b1;
        buf_widx  = fill_q;
        buf_wdata = BLANK_CHAR;
        fill_d    = fill_q + 5'd1;
        if (fill_q == 5'(BUF_DEPTH - 1)) begin
          state_d = ST_BUSY;
          cnt_d   = TAIL_LOAD;
        end
      end

      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 32'd1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= LINE1_BASE;
      id_q       <= 1'b1;
      disp_q     <= 1'b0;
      perr_q     <= 1'b0;
      cmd_rs_q   <= 1'b0;
      cmd_data_q <= 8'h00;
      fill_q     <= 5'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      disp_q     <= disp_d;
      perr_q     <= perr_d;
      cmd_rs_q   <= cmd_rs_d;
      cmd_data_q <= cmd_data_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
    end
  end

  // NOTE: the buffer is reset because a blank screen right after reset is visible on rd_data.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= BLANK_CHAR;
    end else if (buf_we) begin
      buf_q[buf_widx] <= buf_wdata;
    end
  end

  assign rd_data      = buf_q[rd_addr];
  assign disp_on      = disp_q;
  assign protocol_err = perr_q;
  assign LCD_DATA_oe  = en_s & rw_s;
  assign LCD_DATA_out = !LCD_DATA_oe ? 8'h00
                      : rs_s         ? buf_q[addr_index(addr_q)]
                      :                {busy, addr_q};

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Randomised scoreboard bench for lcd_bus_responder against a position-based display model.
module tb_lcd_bus_responder;

  localparam int BUSY_CYCLES  = 40;
  localparam int CLEAR_CYCLES = 200;

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic       LCD_RS, LCD_RW, LCD_EN;
  logic [7:0] LCD_DATA_in;
  logic [7:0] LCD_DATA_out;
  logic       LCD_DATA_oe;
  logic       busy, disp_on;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       protocol_err;

  always #5 Clock = ~Clock;

  lcd_bus_responder #(
    .BUSY_CYCLES  (BUSY_CYCLES),
    .CLEAR_CYCLES (CLEAR_CYCLES)
  ) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .LCD_RS       (LCD_RS),
    .LCD_RW       (LCD_RW),
    .LCD_EN       (LCD_EN),
    .LCD_DATA_in  (LCD_DATA_in),
    .LCD_DATA_out (LCD_DATA_out),
    .LCD_DATA_oe  (LCD_DATA_oe),
    .busy         (busy),
    .disp_on      (disp_on),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .protocol_err (protocol_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: the display is 32 linear positions; DDRAM addresses are just a view of them.
  logic [7:0] m_buf [32];
  int         m_addr;
  bit         m_id, m_disp, m_busy;

  function automatic int a2pos(input int a);
    return (a >= 64) ? a - 48 : a;
  endfunction

  function automatic int pos2a(input int p);
    return (p < 16) ? p : p + 48;
  endfunction

  function automatic int step(input int a, input bit inc);
    return pos2a((a2pos(a) + (inc ? 1 : 31)) % 32);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    m_addr = 0;
    m_id   = 1'b1;
    m_disp = 1'b0;
    m_busy = 1'b0;
  endtask

  typedef struct {
    bit         is_read;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  task automatic sb_push(input bit is_read, input logic [7:0] val, input string tag);
    exp_t e;
    e.is_read = is_read;
    e.val     = val;
    e.tag     = tag;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input bit is_read, input logic [7:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_%s: got 0x%0h, expected none", is_read ? "read" : "protocol_err", act);
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, "_kind"}, 32'(is_read), 32'(e.is_read));
    if (is_read) check(e.tag, act, e.val);
  endtask

  // Monitor: every bus read presentation and every protocol_err pulse consumes one expectation.
  logic oe_prev = 1'b0;
  always @(negedge Clock) begin
    if (LCD_DATA_oe && !oe_prev) sb_pop(1'b1, LCD_DATA_out);
    if (protocol_err)            sb_pop(1'b0, 8'h00);
    oe_prev = LCD_DATA_oe;
  end

  int busy_run = 0;
  int busy_len = 0;
  always @(negedge Clock) begin
    if (busy) busy_run++;
    else begin
      if (busy_run != 0) busy_len = busy_run;
      busy_run = 0;
    end
  end

  task automatic bus_xfer(input bit rs, input bit rw, input logic [7:0] d,
                          input int chk_pos, input logic [7:0] chk_val);
    @(posedge Clock); #1;
    LCD_RS = rs; LCD_RW = rw; LCD_DATA_in = d;
    repeat (2) @(posedge Clock); #1 LCD_EN = 1'b1;
    repeat (6) @(posedge Clock); #1 LCD_EN = 1'b0;
    repeat (4) @(posedge Clock); #1;
    if (chk_pos >= 0) begin
      rd_addr = 5'(chk_pos);
      #1 check("rd_data_latency", 32'(rd_data), 32'(chk_val));
    end
    repeat (2) @(posedge Clock); #1;
  endtask

  task automatic wait_idle(input int exp_len);
    int n = 0;
    while (busy && n < CLEAR_CYCLES + 100) begin
      @(negedge Clock);
      n++;
    end
    if (busy) begin
      n_total++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles, expected 0", n);
    end
    @(negedge Clock);
    check("busy_length", 32'(busy_len), 32'(exp_len));
    m_busy = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic do_write(input bit rs, input logic [7:0] d, input bit wait_done);
    int         exp_len = BUSY_CYCLES;
    int         cp = -1;
    logic [7:0] cv = 8'h00;
    int         dv = int'(d);
    int         a;
    if (m_busy) begin
      sb_push(1'b0, 8'h00, "ignored_write");
      bus_xfer(rs, 1'b0, d, -1, 8'h00);
      return;
    end
    if (rs) begin
      cp = a2pos(m_addr);
      cv = d;
      m_buf[cp] = d;
      m_addr = step(m_addr, m_id);
    end else if (dv == 1) begin
      for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
      m_addr  = 0;
      m_id    = 1'b1;
      exp_len = CLEAR_CYCLES;
    end else if (dv >= 2 && dv <= 3) begin
      m_addr = 0;
    end else if (dv >= 4 && dv <= 7) begin
      m_id = d[1];
    end else if (dv >= 8 && dv <= 15) begin
      m_disp = d[2];
    end else if (dv >= 16 && dv <= 31) begin
      if (!d[3]) m_addr = step(m_addr, d[2]);
    end else if (dv >= 128) begin
      a = dv - 128;
      if (a < 16 || (a >= 64 && a < 80)) m_addr = a;
      else sb_push(1'b0, 8'h00, "bad_ddram");
    end
    busy_len = 0;
    bus_xfer(rs, 1'b0, d, cp, cv);
    m_busy = 1'b1;
    if (wait_done) wait_idle(exp_len);
  endtask

  task automatic do_read(input bit rs);
    logic [7:0] v;
    if (rs) v = m_buf[a2pos(m_addr)];
    else    v = {m_busy, 7'(m_addr)};
    sb_push(1'b1, v, rs ? "data_read" : "status_read");
    bus_xfer(rs, 1'b1, 8'h00, -1, 8'h00);
    if (rs) m_addr = step(m_addr, m_id);
    if (!m_busy) check("read_no_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_buffer(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1 check($sformatf("%s_buf%0d", tag, i), 32'(rd_data), 32'(m_buf[i]));
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    #1;
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_oe",       32'(LCD_DATA_oe),  32'd0);
    check("rst_data_out", 32'(LCD_DATA_out), 32'd0);
    check("rst_perr",     32'(protocol_err), 32'd0);
    check("rst_disp_on",  32'(disp_on),      32'd0);
    model_reset();
    repeat (3) @(posedge Clock);
    #1 Reset_n = 1'b1;
    @(posedge Clock); #1;
  endtask

  initial begin
    Reset_n = 1'b0; LCD_EN = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0;
    LCD_DATA_in = 8'h00; rd_addr = 5'd0;
    do_reset();
    check_buffer("reset");

    // "LED" from the start of line 1, then status shows the cursor at 0x03.
    do_write(1'b0, 8'h80, 1'b1);
    do_write(1'b1, 8'h4C, 1'b1);
    do_write(1'b1, 8'h45, 1'b1);
    do_write(1'b1, 8'h44, 1'b1);
    check_buffer("led");
    do_read(1'b0);

    // Crossing from the end of line 1 onto line 2.
    do_write(1'b0, 8'h8F, 1'b1);
    do_write(1'b1, 8'h41, 1'b1);
    do_write(1'b1, 8'h42, 1'b1);
    check_buffer("wrap");
    do_read(1'b0);

    do_write(1'b0, 8'h80, 1'b1);
    do_read(1'b1);
    do_read(1'b1);
    do_read(1'b0);

    // Decrement mode wraps 0x00 back to 0x4F.
    do_write(1'b0, 8'h04, 1'b1);
    do_write(1'b0, 8'h80, 1'b1);
    do_write(1'b1, 8'h58, 1'b1);
    check_buffer("dec");
    do_read(1'b0);
    do_write(1'b0, 8'h14, 1'b1);
    do_read(1'b0);
    do_write(1'b0, 8'h10, 1'b1);
    do_write(1'b0, 8'h1C, 1'b1);
    do_read(1'b0);
    do_write(1'b0, 8'h06, 1'b1);
    do_write(1'b0, 8'h90, 1'b1);
    do_read(1'b0);
    do_write(1'b0, 8'hC5, 1'b1);
    do_read(1'b0);

    for (int k = 0; k < 50; k++) begin
      case ($urandom_range(0, 7))
        0, 1:    do_write(1'b1, 8'($urandom_range(33, 126)), 1'b1);
        2:       do_write(1'b0, 8'($urandom_range(128, 255)), 1'b1);
        3:       do_write(1'b0, 8'(4 + $urandom_range(0, 3)), 1'b1);
        4:       do_write(1'b0, 8'(16 + $urandom_range(0, 15)), 1'b1);
        5:       do_read(1'b1);
        6:       do_read(1'b0);
        default: do_write(1'b0, 8'($urandom_range(2, 15)), 1'b1);
      endcase
    end
    check_buffer("random");
    check("disp_on_random", 32'(disp_on), 32'(m_disp));

    // Clear: status mid-clear, a rejected data write, full busy time, blank buffer.
    do_write(1'b0, 8'h01, 1'b0);
    do_read(1'b0);
    do_write(1'b1, 8'h5A, 1'b0);
    wait_idle(CLEAR_CYCLES);
    check_buffer("clear");
    do_read(1'b0);

    do_write(1'b1, 8'h33, 1'b0);
    do_write(1'b1, 8'h44, 1'b0);
    wait_idle(BUSY_CYCLES);
    check_buffer("ignored");

    // Reset in the middle of BUSY, then a display-on command is accepted at once.
    do_write(1'b0, 8'h08, 1'b0);
    check("busy_before_reset", 32'(busy), 32'd1);
    do_reset();
    check_buffer("midreset");
    do_write(1'b0, 8'h0C, 1'b1);
    check("disp_on_after_reset", 32'(disp_on), 32'd1);

    repeat (5) @(posedge Clock);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
